residual_requant_64: RTL and testbench



---
 rtl/residual_requant_pkg.sv | 24 ++
 rtl/residual_requant_64_lane.sv | 26 ++
 rtl/residual_requant_64.sv | 72 +++++++
 tb/tb_residual_requant_64.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/residual_requant_pkg.sv
// residual_requant_pkg: shared widths, int8 limits and the saturating clip for residual requantisation
package residual_requant_pkg;
  localparam int DIMENTION = 64;
  localparam int WIDTH_SUM = 9;
  localparam int WIDTH_SCALE = 8;
  localparam int WIDTH_SHIFT = 4;
  localparam int WIDTH_OUT = 8;
  localparam int WIDTH_PROD = 17;
  localparam int WIDTH_RND = 18;
  localparam int WIDTH_ROWSUM = WIDTH_OUT + 6;
  localparam int WIDTH_SATCNT = 7;
  localparam int INT8_MAX = 127;
  localparam int INT8_MIN = -128;
  typedef struct packed {
    logic sat;
    logic signed [WIDTH_OUT-1:0] q;
  } sat_t;
  function automatic sat_t saturate(input logic signed [WIDTH_RND-1:0] x);
    sat_t s;
    s.sat = (x > INT8_MAX) || (x < INT8_MIN);
    s.q = x > INT8_MAX ? WIDTH_OUT'(INT8_MAX) : x < INT8_MIN ? WIDTH_OUT'(INT8_MIN) : x[WIDTH_OUT-1:0];
    return s;
  endfunction
endpackage

// File: rtl/residual_requant_64_lane.sv
// requant_lane: registered exact product of one lane, then round-half-up shift and int8 clip
module requant_lane
  import residual_requant_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load,
  input  logic signed [WIDTH_SUM-1:0]   sum,
  input  logic [WIDTH_SCALE-1:0]        scale,
  input  logic [WIDTH_SHIFT-1:0]        shift,
  output logic signed [WIDTH_OUT-1:0]   q,
  output logic                          sat
);
  logic signed [WIDTH_PROD-1:0] prod;
  logic signed [WIDTH_RND-1:0] bias, rnd;
  sat_t s;
  always_ff @(posedge clk or posedge rst)
    if (rst) prod <= '0;
    else if (load) prod <= WIDTH_PROD'(sum) * WIDTH_PROD'($signed({1'b0, scale}));
  // one extra bit of headroom so the rounding term can never overflow
  assign bias = shift != '0 ? WIDTH_RND'(1) << (shift - WIDTH_SHIFT'(1)) : '0;
  assign rnd = (WIDTH_RND'(prod) + bias) >>> shift;
  assign s = saturate(rnd);
  assign q = s.q;
  assign sat = s.sat;
endmodule

// File: rtl/residual_requant_64.sv
// residual_requant_64: two-stage valid/ready requantiser of 64 residual lanes to int8 with row sum and clip count
module residual_requant_64
  import residual_requant_pkg::*;
(
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [WIDTH_SUM*DIMENTION-1:0]      sum,
  input  logic [WIDTH_SCALE-1:0]              scale,
  input  logic [WIDTH_SHIFT-1:0]              shift,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [WIDTH_OUT*DIMENTION-1:0]      data_out,
  output logic signed [WIDTH_ROWSUM-1:0]      row_sum,
  output logic [WIDTH_SATCNT-1:0]             sat_count
);
  logic s1_valid, s2_valid, s1_adv, s2_adv, accept;
  logic [WIDTH_SHIFT-1:0] s1_shift;
  logic signed [WIDTH_OUT-1:0] q [DIMENTION];
  logic [DIMENTION-1:0] sat;
  logic [WIDTH_OUT*DIMENTION-1:0] q_flat;
  logic signed [WIDTH_ROWSUM-1:0] rs_next;
  logic [WIDTH_SATCNT-1:0] sc_next;
  assign s2_adv = !s2_valid || out_ready;
  assign s1_adv = s1_valid && s2_adv;
  assign in_ready = !s1_valid || s2_adv;
  assign accept = in_valid && in_ready;
  assign out_valid = s2_valid;
  for (genvar i = 0; i < DIMENTION; i++) begin : g_lane
    requant_lane u_lane (
      .clk   (clk),
      .rst   (rst),
      .load  (accept),
      .sum   (sum[(DIMENTION-1-i)*WIDTH_SUM +: WIDTH_SUM]),
      .scale (scale),
      .shift (s1_shift),
      .q     (q[i]),
      .sat   (sat[i])
    );
    assign q_flat[(DIMENTION-1-i)*WIDTH_OUT +: WIDTH_OUT] = q[i];
  end
  // 64 x int8 spans -8192..8128, so 14 bits hold the row sum exactly
  always_comb begin
    rs_next = '0;
    sc_next = '0;
    for (int i = 0; i < DIMENTION; i++) begin
      rs_next = rs_next + WIDTH_ROWSUM'(q[i]);
      sc_next = sc_next + WIDTH_SATCNT'(sat[i]);
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_shift <= '0;
      data_out <= '0;
      row_sum <= '0;
      sat_count <= '0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_shift <= shift;
      end else if (s1_adv) s1_valid <= 1'b0;
      if (s1_adv) begin
        s2_valid <= 1'b1;
        data_out <= q_flat;
        row_sum <= rs_next;
        sat_count <= sc_next;
      end else if (out_ready) s2_valid <= 1'b0;
    end
endmodule

// File: tb/tb_residual_requant_64.sv
// tb_residual_requant_64: table vectors, stall/reset sequences and random streaming against a floor-division model
module tb_residual_requant_64;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid;
  logic [575:0] sum = '0;
  logic [7:0] scale = '0;
  logic [3:0] shift = '0;
  logic [511:0] data_out;
  logic signed [13:0] row_sum;
  logic [6:0] sat_count;
  typedef struct {logic [511:0] d; int rs; int sc;} exp_t;
  typedef struct {int l0, l1, l2, fe, fo, scale, shift, q0, q1, q2, qe, qo, rs, sc;} vec_t;
  exp_t sb[$];
  vec_t tbl[8];
  int checks = 0, errors = 0, acc_cnt = 0, out_cnt = 0, cyc = 0;
  bit held = 0, done = 0;
  exp_t prev;

  residual_requant_64 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .sum(sum),
    .scale(scale), .shift(shift), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .row_sum(row_sum), .sat_count(sat_count)
  );

  initial forever #5 clk = ~clk;
  initial forever @(posedge clk) cyc++;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic int pick(int i, int l0, int l1, int l2, int fe, int fo);
    return i == 0 ? l0 : i == 1 ? l1 : i == 2 ? l2 : (i % 2 == 0) ? fe : fo;
  endfunction
  function automatic logic [575:0] pack_in(int l0, int l1, int l2, int fe, int fo);
    logic [575:0] r;
    for (int i = 0; i < 64; i++) r[(63-i)*9 +: 9] = 9'(pick(i, l0, l1, l2, fe, fo));
    return r;
  endfunction
  function automatic logic [511:0] pack_out(int l0, int l1, int l2, int fe, int fo);
    logic [511:0] r;
    for (int i = 0; i < 64; i++) r[(63-i)*8 +: 8] = 8'(pick(i, l0, l1, l2, fe, fo));
    return r;
  endfunction
  function automatic logic [575:0] rand_vec();
    logic [575:0] r;
    for (int i = 0; i < 64; i++) r[(63-i)*9 +: 9] = 9'($urandom_range(0, 511));
    return r;
  endfunction
  // reference: round-half-up as floor((x*scale + half) / 2^shift), then clip to int8
  function automatic exp_t model(logic [575:0] s, int sc, int sh);
    exp_t e;
    int x, n, d, r;
    e.d = '0; e.rs = 0; e.sc = 0;
    for (int i = 0; i < 64; i++) begin
      x = int'($signed(s[(63-i)*9 +: 9]));
      n = x * sc + (sh == 0 ? 0 : 2 ** (sh - 1));
      d = 2 ** sh;
      r = n / d;
      if (n % d != 0 && n < 0) r = r - 1;
      if (r > 127) begin r = 127; e.sc++; end
      else if (r < -128) begin r = -128; e.sc++; end
      e.d[(63-i)*8 +: 8] = 8'(r);
      e.rs += r;
    end
    return e;
  endfunction

  task automatic chk_int(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic chk_vec(string name, logic [511:0] act, logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic send(input logic [575:0] v, input int sc, input int sh);
    int n;
    n = 0;
    sum = v; scale = 8'(sc); shift = 4'(sh); in_valid = 1;
    @(negedge clk);
    while (!in_ready && n < 300) begin n++; @(negedge clk); end
    if (n >= 300) begin checks++; errors++; $display("FAIL send_timeout: in_ready stuck at %0d expected 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 0;
  endtask
  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin @(posedge clk); n++; end
    if (n >= 500) begin checks++; errors++; $display("FAIL drain_timeout: %0d pending expected 0", sb.size()); end
    @(posedge clk); #1;
  endtask

  // monitor: scoreboard on both transfers, plus hold-stable check while stalled
  initial begin
    exp_t e;
    forever @(negedge clk) begin
      if (rst) held = 0;
      else begin
        if (held) begin
          chk_int("stall_valid", out_valid, 1);
          chk_vec("stall_data", data_out, prev.d);
          chk_int("stall_rowsum", row_sum, prev.rs);
          chk_int("stall_satcnt", sat_count, prev.sc);
        end
        held = out_valid && !out_ready;
        prev.d = data_out; prev.rs = int'(row_sum); prev.sc = int'(sat_count);
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_output: got out_valid=1 expected no pending vector");
          end else begin
            e = sb.pop_front();
            chk_vec("sb_data", data_out, e.d);
            chk_int("sb_rowsum", row_sum, e.rs);
            chk_int("sb_satcnt", sat_count, e.sc);
          end
          out_cnt++;
        end
        if (in_valid && in_ready) begin
          sb.push_back(model(sum, int'(scale), int'(shift)));
          acc_cnt++;
        end
      end
    end
  end

  initial begin
    int base_a, base_o, t0;
    tbl[0] = '{5, -5, 6, 0, 0, 3, 2, 4, -4, 5, 0, 0, 5, 0};
    tbl[1] = '{255, -256, 255, 255, -256, 1, 0, 127, -128, 127, 127, -128, -32, 64};
    tbl[2] = '{127, 127, 127, 127, 127, 1, 0, 127, 127, 127, 127, 127, 8128, 0};
    tbl[3] = '{-128, -128, -128, -128, -128, 1, 0, -128, -128, -128, -128, -128, -8192, 0};
    tbl[4] = '{255, -256, 255, 255, -256, 0, 5, 0, 0, 0, 0, 0, 0, 0};
    tbl[5] = '{255, 255, 255, 255, 255, 255, 15, 2, 2, 2, 2, 2, 128, 0};
    tbl[6] = '{3, -3, 1, 3, -3, 2, 0, 6, -6, 2, 6, -6, -4, 0};
    tbl[7] = '{-1, 1, -3, 0, 0, 1, 1, 0, 1, -1, 0, 0, 0, 0};
    repeat (3) @(posedge clk);
    #1;
    chk_int("rst_out_valid", out_valid, 0);
    chk_vec("rst_data", data_out, '0);
    chk_int("rst_rowsum", row_sum, 0);
    chk_int("rst_satcnt", sat_count, 0);
    rst = 0;
    #1;
    chk_int("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    foreach (tbl[k]) begin
      sum = pack_in(tbl[k].l0, tbl[k].l1, tbl[k].l2, tbl[k].fe, tbl[k].fo);
      scale = 8'(tbl[k].scale); shift = 4'(tbl[k].shift);
      in_valid = 1; out_ready = 1;
      @(negedge clk);
      chk_int("tbl_in_ready", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 0;
      chk_int("tbl_latency1", out_valid, 0);
      @(posedge clk); #1;
      chk_int("tbl_latency2", out_valid, 1);
      chk_vec("tbl_data", data_out, pack_out(tbl[k].q0, tbl[k].q1, tbl[k].q2, tbl[k].qe, tbl[k].qo));
      chk_int("tbl_rowsum", row_sum, tbl[k].rs);
      chk_int("tbl_satcnt", sat_count, tbl[k].sc);
      @(posedge clk); #1;
    end

    base_a = acc_cnt; base_o = out_cnt;
    out_ready = 0;
    fork
      for (int k = 0; k < 4; k++) send(rand_vec(), $urandom_range(0, 255), $urandom_range(0, 15));
      begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk_int("bp_accepts", acc_cnt - base_a, 2);
        chk_int("bp_in_ready", in_ready, 0);
        @(posedge clk); #1;
        out_ready = 1;
      end
    join
    drain();
    chk_int("bp_out_count", out_cnt - base_o, 4);
    chk_int("bp_out_valid_idle", out_valid, 0);

    base_o = out_cnt;
    t0 = cyc;
    for (int k = 0; k < 20; k++) send(rand_vec(), $urandom_range(1, 255), $urandom_range(0, 15));
    chk_int("tput_cycles", cyc - t0, 20);
    drain();
    chk_int("tput_out_count", out_cnt - base_o, 20);

    base_o = out_cnt;
    done = 0;
    fork
      begin
        for (int k = 0; k < 100; k++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          send(rand_vec(), $urandom_range(0, 255), $urandom_range(0, 15));
        end
        done = 1;
      end
      begin
        while (!done) begin
          out_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
        out_ready = 1;
      end
    join
    drain();
    chk_int("stream_out_count", out_cnt - base_o, 100);
    chk_int("stream_sb_empty", sb.size(), 0);

    out_ready = 0;
    send(rand_vec(), 200, 3);
    send(rand_vec(), 100, 1);
    #1;
    rst = 1;
    #1;
    chk_int("midrst_out_valid", out_valid, 0);
    chk_vec("midrst_data", data_out, '0);
    chk_int("midrst_rowsum", row_sum, 0);
    chk_int("midrst_satcnt", sat_count, 0);
    sb.delete();
    @(posedge clk); #1;
    rst = 0;
    out_ready = 1;
    base_o = out_cnt;
    send(pack_in(5, -5, 6, 0, 0), 3, 2);
    @(posedge clk); #1;
    chk_int("postrst_valid", out_valid, 1);
    chk_vec("postrst_data", data_out, pack_out(4, -4, 5, 0, 0));
    chk_int("postrst_rowsum", row_sum, 5);
    drain();
    chk_int("postrst_out_count", out_cnt - base_o, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
